instr_mem_ctrl: RTL

//   Parametrised, loadable instruction memory for the MIPS datapath; successor to the fixed combinational ROM.
//   - Program image is streamed in over a boot-load port.
//   - The fetch stage then reads words through a valid/ready request port.
//   - Reads are synchronous with 1-cycle latency.
//   - Out-of-range fetches return a NOP and raise a fault.

---
 rtl/instr_mem_pkg.sv | 18 +
 rtl/instr_mem_ram.sv | 36 +++
 rtl/instr_mem_ctrl.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/instr_mem_pkg.sv
// Shared types and helpers for the loadable instruction memory.
// Parity storage is enabled by defining INSTR_MEM_PARITY_EN.
package instr_mem_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        LOAD = 1'b1
    } state_t;

    localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0000;
    localparam int          PARITY_MAX_W     = 64;

    // Even-parity bit: the stored word plus this bit always carries an even number of ones.
    function automatic logic even_parity(input logic [PARITY_MAX_W-1:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/instr_mem_ram.sv
// Single-port synchronous RAM with write enable and a registered, enabled read.
// The array itself is never reset; only the read register is.
module instr_mem_ram #(
    parameter int               WIDTH   = 32,
    parameter int               DEPTH   = 256,
    parameter int               ADDR_W  = 8,
    parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WIDTH-1:0]  wdata,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Array write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    // Read register holds its word until the next enabled read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= RST_VAL;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/instr_mem_ctrl.sv
// Loadable instruction memory: boot-load stream in, valid/ready fetch port out.
// Define INSTR_MEM_PARITY_EN to store and check an even-parity bit per word.
module instr_mem_ctrl
    import instr_mem_pkg::*;
#(
    parameter int                DATA_W   = 32,
    parameter int                ADDR_W   = 8,
    parameter int                DEPTH    = 256,
    parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(NOP_WORD_DEFAULT)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_start,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    output logic              load_done,
    output logic              load_err,
    input  logic              req_valid,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              req_ready,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_fault
);

`ifdef INSTR_MEM_PARITY_EN
    localparam int               RAM_W   = DATA_W + 1;
    localparam logic [RAM_W-1:0] RAM_RST = {even_parity(PARITY_MAX_W'(NOP_WORD)), NOP_WORD};
`else
    localparam int               RAM_W   = DATA_W;
    localparam logic [RAM_W-1:0] RAM_RST = NOP_WORD;
`endif

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_L  = (ADDR_W + 1)'(DEPTH);

    state_t            state_r, state_nxt_s;
    logic [ADDR_W-1:0] wr_ptr_r, wr_ptr_nxt_s;
    logic              load_err_r, load_err_nxt_s;
    logic              load_done_r, load_done_nxt_s;
    logic              rsp_valid_r;
    logic              range_fault_r;
    logic              wr_en_s;
    logic              accept_s;
    logic              in_range_s;
    logic              parity_bad_s;
    logic [ADDR_W-1:0] ram_addr_s;
    logic [RAM_W-1:0]  ram_wdata_s;
    logic [RAM_W-1:0]  ram_rdata_s;

    // Next-state, write pointer and load status; load_start always wins over fetches.
    always_comb begin
        state_nxt_s     = state_r;
        wr_ptr_nxt_s    = wr_ptr_r;
        load_err_nxt_s  = load_err_r;
        load_done_nxt_s = 1'b0;
        wr_en_s         = 1'b0;
        req_ready       = 1'b0;
        case (state_r)
            IDLE: begin
                req_ready = ~load_start;
                if (load_start) begin
                    state_nxt_s    = LOAD;
                    wr_ptr_nxt_s   = {ADDR_W{1'b0}};
                    load_err_nxt_s = 1'b0;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            LOAD: begin
                if (load_start) begin
                    wr_ptr_nxt_s   = {ADDR_W{1'b0}};
                    load_err_nxt_s = 1'b0;
                end else if (load_valid) begin
                    wr_en_s = 1'b1;
                    if (wr_ptr_r == LAST_IDX) begin
                        wr_ptr_nxt_s   = {ADDR_W{1'b0}};
                        load_err_nxt_s = load_err_r | ~load_last;
                    end else begin
                        wr_ptr_nxt_s = wr_ptr_r + ADDR_W'(1);
                    end
                    if (load_last) begin
                        state_nxt_s     = IDLE;
                        load_done_nxt_s = 1'b1;
                    end else begin
                        state_nxt_s = LOAD;
                    end
                end else begin
                    state_nxt_s = LOAD;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    assign accept_s   = req_valid & req_ready;
    assign in_range_s = ({1'b0, req_addr} < DEPTH_L);
    assign ram_addr_s = (state_r == LOAD) ? wr_ptr_r : req_addr;

`ifdef INSTR_MEM_PARITY_EN
    assign ram_wdata_s  = {even_parity(PARITY_MAX_W'(load_data)), load_data};
    assign parity_bad_s = ram_rdata_s[DATA_W] ^ even_parity(PARITY_MAX_W'(ram_rdata_s[DATA_W-1:0]));
`else
    assign ram_wdata_s  = load_data;
    assign parity_bad_s = 1'b0;
`endif

    // Control registers: FSM, pointer, load status and response qualifiers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= IDLE;
            wr_ptr_r      <= {ADDR_W{1'b0}};
            load_err_r    <= 1'b0;
            load_done_r   <= 1'b0;
            rsp_valid_r   <= 1'b0;
            range_fault_r <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            wr_ptr_r      <= wr_ptr_nxt_s;
            load_err_r    <= load_err_nxt_s;
            load_done_r   <= load_done_nxt_s;
            rsp_valid_r   <= accept_s;
            range_fault_r <= accept_s ? ~in_range_s : range_fault_r;
        end
    end

    // Out-of-range fetches skip the RAM read; the fault flag masks the stale word instead.
    instr_mem_ram #(
        .WIDTH   (RAM_W),
        .DEPTH   (DEPTH),
        .ADDR_W  (ADDR_W),
        .RST_VAL (RAM_RST)
    ) u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (wr_en_s),
        .re    (accept_s & in_range_s),
        .addr  (ram_addr_s),
        .wdata (ram_wdata_s),
        .rdata (ram_rdata_s)
    );

    assign load_done = load_done_r;
    assign load_err  = load_err_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_fault = range_fault_r | parity_bad_s;
    assign rsp_data  = rsp_fault ? NOP_WORD : ram_rdata_s[DATA_W-1:0];

endmodule
